// File: rtl/angle_pkg.sv
// Shared angle constants and the degree-to-radian converter state type.
// Used by the deg/rad conversion paths.
package angle_pkg;

  localparam int DEG_PER_TURN  = 360;
  localparam int DEG_HALF_TURN = 180;

  localparam logic signed [31:0] PI_OVER_180_Q28 = 32'sd4685083;

  localparam logic signed [15:0] Q14_MAX   = 16'sh7FFF;
  localparam logic signed [15:0] Q14_MIN   = 16'sh8000;
  localparam int                 Q14_ROUND = 8192;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    FOLD,
    MULT,
    HOLD
  } d2r_state_t;

endpackage

// File: rtl/q28_to_q14_round_sat.sv
// Combinational round-half-up and saturation of a Q28-scaled product
// down to signed Q1.14, with a flag when the result was clipped.
module q28_to_q14_round_sat
  import angle_pkg::*;
(
  input  logic signed [31:0] product_i,
  output logic signed [15:0] rad_q14_o,
  output logic               sat_o
);

  logic signed [32:0] sum;
  logic signed [32:0] shifted;

  // One guard bit keeps the rounding add from wrapping near the 32-bit limit.
  assign sum     = $signed({product_i[31], product_i}) + 33'(Q14_ROUND);
  assign shifted = sum >>> 14;

  always_comb begin
    rad_q14_o = shifted[15:0];
    sat_o     = 1'b0;
    if (shifted > 33'(Q14_MAX)) begin
      rad_q14_o = Q14_MAX;
      sat_o     = 1'b1;
    end else if (shifted < 33'(Q14_MIN)) begin
      rad_q14_o = Q14_MIN;
      sat_o     = 1'b1;
    end
  end

endmodule

// File: rtl/deg_to_rad_seq.sv
// Sequential integer-degree to Q1.14 radian converter: iterative modulo-360
// reduction, fold to [-180, 180), multiply by pi/180, round and saturate.
module deg_to_rad_seq
  import angle_pkg::*;
#(
  parameter int DEG_W     = 16,
  parameter int RED_STEPS = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DEG_W-1:0] in_deg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_rad_q14,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int K_W = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;
  localparam logic [K_W-1:0] K_INIT = K_W'(RED_STEPS - 1);

  d2r_state_t          state_q, state_d;
  logic                s_q, s_d;
  logic [DEG_W:0]      m_q, m_d;
  logic [K_W-1:0]      k_q, k_d;
  logic signed [9:0]   r_q, r_d;
  logic                valid_q, valid_d;
  logic signed [15:0]  rad_q, rad_d;
  logic                sat_q, sat_d;

  logic [DEG_W:0]      absIn;
  logic [31:0]         mExt;
  logic [31:0]         step;
  logic signed [10:0]  mSmall;
  logic signed [10:0]  rFold;
  logic signed [31:0]  rExt;
  logic signed [31:0]  product;
  logic signed [15:0]  roundRad;
  logic                roundSat;

  // Magnitude carries one extra bit so the most negative input stays positive.
  assign absIn = in_deg[DEG_W-1] ? ({1'b0, ~in_deg} + 1'b1) : {1'b0, in_deg};
  assign mExt  = {{(31-DEG_W){1'b0}}, m_q};
  assign step  = 32'(DEG_PER_TURN) << k_q;

  assign mSmall = $signed({2'b00, m_q[8:0]});

  always_comb begin
    rFold = s_q ? -mSmall : mSmall;
    if (rFold >= 11'(DEG_HALF_TURN)) begin
      rFold = rFold - 11'(DEG_PER_TURN);
    end else if (rFold < -11'(DEG_HALF_TURN)) begin
      rFold = rFold + 11'(DEG_PER_TURN);
    end
  end

  assign rExt    = {{22{r_q[9]}}, r_q};
  assign product = rExt * PI_OVER_180_Q28;

  q28_to_q14_round_sat u_round_sat (
    .product_i (product),
    .rad_q14_o (roundRad),
    .sat_o     (roundSat)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    m_d     = m_q;
    k_d     = k_q;
    r_d     = r_q;
    valid_d = valid_q;
    rad_d   = rad_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_deg[DEG_W-1];
          m_d     = absIn;
          k_d     = K_INIT;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (mExt >= step) begin
          m_d = m_q - step[DEG_W:0];
        end
        if (k_q == '0) begin
          state_d = FOLD;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      FOLD: begin
        r_d     = rFold[9:0];
        state_d = MULT;
      end
      MULT: begin
        rad_d   = roundRad;
        sat_d   = roundSat;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      rad_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      m_q     <= m_d;
      k_q     <= k_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      rad_q   <= rad_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_rad_q14 = rad_q;
  assign out_sat     = sat_q;

endmodule

// File: tb/tb_deg_to_rad_seq.sv
// Scoreboard bench for deg_to_rad_seq: directed angles with hand-computed
// Q1.14 results, latency, backpressure and mid-operation reset.
module tb_deg_to_rad_seq;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_deg;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_rad_q14;
  logic               out_sat;
  logic               busy;

  typedef struct {
    int rad;
    int sat;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  deg_to_rad_seq #(.DEG_W(16), .RED_STEPS(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_deg      (in_deg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rad_q14 (out_rad_q14),
    .out_sat     (out_sat),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compares each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("out_rad_q14", int'(out_rad_q14), e.rad);
        checkOutput("out_sat", int'(out_sat), e.sat);
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("in_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic applyStimulus(input int deg, input int expRad, input int expSat);
    exp_t e;
    int   n;
    waitIdle();
    in_valid = 1'b1;
    in_deg   = 16'(deg);
    @(posedge clk);
    e.rad = expRad;
    e.sat = expSat;
    expQ.push_back(e);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("latency", n, 9);
    if (out_ready) begin
      @(posedge clk);
      #1;
      checkOutput("valid_one_cycle", int'(out_valid), 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_deg    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_rad", int'(out_rad_q14), 0);
    checkOutput("rst_sat", int'(out_sat), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(90, 25736, 0);
    applyStimulus(45, 12868, 0);
    applyStimulus(-30, -8579, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(400, 11438, 0);
    applyStimulus(-370, -2860, 0);
    applyStimulus(-32768, -2288, 0);
    applyStimulus(150, 32767, 1);
    applyStimulus(180, -32768, 1);
    applyStimulus(-180, -32768, 1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(90, 25736, 0);
    in_valid = 1'b1;
    in_deg   = 16'sd45;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", int'(out_valid), 1);
      checkOutput("bp_rad", int'(out_rad_q14), 25736);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", int'(out_valid), 0);
    checkOutput("bp_release_in_ready", int'(in_ready), 1);

    $display("[TB] reset mid-reduce");
    applyStimulus(45, 12868, 0);
    waitIdle();
    in_valid = 1'b1;
    in_deg   = 16'sd150;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_rad", int'(out_rad_q14), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(90, 25736, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
